// File: rtl/part_one_decoder_pkg.sv
// Shared constants and state type for the part-one Gray decoder.
package part_one_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam int unsigned P1_WIDTH = 8;

  typedef enum logic [1:0] {
    StIdle   = ST_IDLE,
    StDecode = ST_DECODE,
    StDone   = ST_DONE
  } state_e;

endpackage

// File: rtl/part_one_decoder_if.sv
// Valid/ready handshake bundle for the part-one decoder; slave is the decoder's view.
interface part_one_decoder_if
  import part_one_pkg::*;
#(
  parameter int unsigned WIDTH = P1_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/part_one_bit_slice.sv
// One registered XOR stage of the serial Gray-to-binary chain.
module part_one_bit_slice (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic first_i,
  input  logic code_bit_i,
  output logic bit_o
);
  logic prev_q;

  // The MSB passes straight through; later bits fold in the previously decoded bit.
  assign bit_o = first_i ? code_bit_i : (prev_q ^ code_bit_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else if (en_i) begin
      prev_q <= bit_o;
    end
  end
endmodule

// File: rtl/part_one_decoder.sv
// Bit-serial Gray-to-binary decoder, MSB first, valid/ready on both sides.
// Optional PART_ONE_DECODER_COUNT_EN adds a 16-bit completed-word counter.
module part_one_decoder
  import part_one_pkg::*;
#(
  parameter int unsigned WIDTH = P1_WIDTH
) (
  input logic clk,
  input logic rst,
  part_one_decoder_if.slave bus
`ifdef PART_ONE_DECODER_COUNT_EN
  ,
  output logic [15:0] decode_count
`endif
);
  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] IdxMax = IdxW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             slice_en;
  logic             next_bit;

  part_one_bit_slice u_slice (
    .clk        (clk),
    .rst        (rst),
    .en_i       (slice_en),
    .first_i    (idx_q == IdxMax),
    .code_bit_i (code_q[idx_q]),
    .bit_o      (next_bit)
  );

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    acc_d    = acc_q;
    out_d    = out_q;
    idx_d    = idx_q;
    slice_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          code_d  = bus.in_data;
          acc_d   = '0;
          idx_d   = IdxMax;
          state_d = StDecode;
        end
      end
      StDecode: begin
        slice_en     = 1'b1;
        acc_d[idx_q] = next_bit;
        if (idx_q == '0) begin
          // Separate output register keeps out_data stable until the next DONE entry.
          out_d   = acc_d;
          state_d = StDone;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      code_q  <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      idx_q   <= IdxMax;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q == StDecode);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_data  = out_q;

`ifdef PART_ONE_DECODER_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if ((state_q == StDone) && bus.out_ready) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign decode_count = count_q;
`endif
endmodule

// File: doc/part_one_decoder.md
Name: part_one_decoder

Overview:
- Inverse of the part-one encoder: takes a WIDTH-bit Gray-coded word and recovers the binary word (b[W-1]=g[W-1]; b[i]=b[i+1]^g[i]).
- Bit-serial, one bit per clock, MSB first; sits downstream of the encoder path in the project datapath.
- Valid/ready handshake on both input and output, so it can be chained or stalled.

Parameters:
- WIDTH, 8, width of the coded input word and of the decoded output word (>=2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word (high only in IDLE)
- in_data  input  WIDTH  Gray-coded word
- out_valid  output  1  out_data holds a decoded word
- out_ready  input  1  downstream accepts out_data
- out_data  output  WIDTH  decoded binary word
- busy  output  1  high in DECODE

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high; ports named clk and rst.
- Reset values:
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - out_data=0; internal shift/accumulator registers=0; bit index=WIDTH-1.
- States IDLE, DECODE, DONE.
- IDLE:
  - in_ready=1.
  - On edge where in_valid&in_ready: latch in_data into code register, clear accumulator, index=WIDTH-1, go to DECODE.
- DECODE: busy=1, in_ready=0. Each edge computes one bit:
  - At index WIDTH-1: bit=g[WIDTH-1].
  - Otherwise: bit=prev_bit^g[index]; the bit is written into the accumulator at position index.
  - After the bit at index 0 is written, go to DONE.
  - Takes exactly WIDTH cycles.
- DONE:
  - out_valid=1; out_data=accumulator, held stable while out_ready=0.
  - On edge with out_ready=1: out_valid falls, go to IDLE.
- Latency: if the input handshake is at edge T, out_valid is first high after edge T+WIDTH. Throughput is at most one word per WIDTH+2 cycles.
- in_valid outside IDLE is ignored; in_data is sampled only at the handshake edge.
- out_data changes only on the DONE-entry edge or on reset.
- out_ready stalled indefinitely: block stays in DONE and in_ready stays 0 (no overwrite).
- rst mid-DECODE or in DONE: on that edge everything returns to reset values; the partial word is discarded and no out_valid pulse occurs.
- rst and in_valid on the same edge: rst wins and the word is not accepted.
- All arithmetic is XOR only; no widths beyond WIDTH.

Optional Feature:
- Macro: PART_ONE_DECODER_COUNT_EN.
- Defined:
  - Adds output port decode_count [15:0].
  - Increments by 1 on every output handshake (out_valid&out_ready); wraps 16'hFFFF to 16'h0000.
  - Cleared by rst.
  - The increment and the DONE->IDLE transition happen on the same edge.
- Not defined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package part_one_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_DECODE=2'd1, ST_DONE=2'd2;
  - default width constant P1_WIDTH=8.
- One natural sub-module: part_one_bit_slice, a registered XOR stage producing the next bit from prev_bit and the code bit. Top level owns the FSM, index counter and handshakes.

Test Plan:
- Reset, then in_data=8'b10101011 with in_valid=1, out_ready=1 -> out_data=8'hCD; out_valid first high exactly 8 cycles after the handshake edge, for one cycle.
- Back-to-back words 8'h00, 8'h80, 8'hFF with in_valid held high -> out_data 8'h00, 8'hFF, 8'hAA in order. Each word is accepted only when in_ready=1; the spacing is 10 cycles.
- out_ready=0 for 20 cycles after out_valid with input 8'h80 -> out_data stays 8'hFF and in_ready stays 0. A new in_valid in that time is not accepted; release out_ready, then one handshake and return to IDLE.
- rst asserted 3 cycles into DECODE of 8'hAB -> next cycle all outputs at reset values; no out_valid. A following word 8'hFF decodes to 8'hAA.
- With PART_ONE_DECODER_COUNT_EN: 3 completed decodes give decode_count=3; rst clears it to 0. Preload via 65536 decodes to show wrap to 0.
- WIDTH=4 build, in_data=4'b1011 -> out_data=4'b1101 after exactly 4 DECODE cycles.
